// File: rtl/hist_pkg.sv
// Shared types and defaults for the serial run pattern source.
// Contents:
//   statetype     - FSM encoding: IDLE (no stream bit) / EMIT (run in progress)
//   DEFAULT_LEN_W - default width of the run-length field
package hist_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } statetype;

    localparam int DEFAULT_LEN_W = 4;

endpackage

// File: rtl/hist_shadow.sv
// Expected-flag shadow for the run detector downstream of run_stream_gen.
// Keeps a 2-bit history of emitted bits and flags repeats on the current bit.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   a_out       - current serial bit
//   a_valid     - a_out carries a stream bit this cycle
//   exp_x       - current bit equals the previous emitted bit
//   exp_y       - current bit equals both previous emitted bits
module hist_shadow
    import hist_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a_out,
    input  logic a_valid,
    output logic exp_x,
    output logic exp_y
);

    logic [1:0] hist;   // [0] = most recent emitted bit, [1] = the one before
    logic [1:0] depth;  // how many history entries are meaningful, saturates at 2

    // Gaps leave the history untouched; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist  <= 2'b00;
            depth <= 2'd0;
        end else if (a_valid) begin
            hist <= {hist[0], a_out};
            if (depth != 2'd2) depth <= depth + 2'd1;
        end
    end

    assign exp_x = a_valid && (depth != 2'd0) && (a_out == hist[0]);
    assign exp_y = a_valid && (depth == 2'd2) && (a_out == hist[0]) && (a_out == hist[1]);

endmodule

// File: rtl/run_stream_gen.sv
// Serial run pattern source: turns {bit, length} commands into a gapless
// one-bit-per-clock stream feeding the run detector's 'a' input.
// Optional feature macro: HIST_FLAGS_EN adds exp_x/exp_y expected flags.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake; ready depends on state/counter only
//   cmd_bit, cmd_len    - run value and number of bits (0 = consume, emit nothing)
//   a_out, a_valid      - registered serial bit and its qualifier
//   run_last            - current a_out is the final bit of its run
//   busy                - a run is being emitted
//   exp_x, exp_y        - (HIST_FLAGS_EN only) expected detector flags
module run_stream_gen
    import hist_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             a_out,
    output logic             a_valid,
    output logic             run_last,
    output logic             busy
`ifdef HIST_FLAGS_EN
    ,
    output logic             exp_x,
    output logic             exp_y
`endif
);

    statetype         state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             a_out_nxt, a_valid_nxt;
    logic             accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            a_out     <= 1'b0;
            a_valid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            a_out     <= a_out_nxt;
            a_valid   <= a_valid_nxt;
        end
    end

    // Ready on the last bit of a run lets the next run start with no bubble.
    assign cmd_ready = (state == IDLE) || (remaining == '0);
    assign accept    = cmd_valid && cmd_ready;
    assign run_last  = (state == EMIT) && (remaining == '0);
    assign busy      = (state == EMIT);

    always_comb begin
        state_nxt     = IDLE;
        remaining_nxt = '0;
        a_out_nxt     = a_out;   // held through gaps
        a_valid_nxt   = 1'b0;
        if (accept) begin
            // A zero-length command is swallowed and always leaves a one-cycle gap.
            if (cmd_len != '0) begin
                state_nxt     = EMIT;
                remaining_nxt = cmd_len - 1'b1;
                a_out_nxt     = cmd_bit;
                a_valid_nxt   = 1'b1;
            end
        end else if ((state == EMIT) && (remaining != '0)) begin
            state_nxt     = EMIT;
            remaining_nxt = remaining - 1'b1;
            a_valid_nxt   = 1'b1;
        end
    end

`ifdef HIST_FLAGS_EN
    hist_shadow u_hist_shadow (
        .clk     (clk),
        .reset   (reset),
        .a_out   (a_out),
        .a_valid (a_valid),
        .exp_x   (exp_x),
        .exp_y   (exp_y)
    );
`endif

endmodule

// File: tb/tb_run_stream_gen.sv
// Bench for run_stream_gen: per-cycle vector table with expected outputs,
// plus a bit scoreboard fed on every accepted command and drained on a_valid.
module tb_run_stream_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_bit = 1'b0;
    logic [3:0] cmd_len = 4'd0;
    logic       cmd_ready, a_out, a_valid, run_last, busy;
`ifdef HIST_FLAGS_EN
    logic       exp_x, exp_y;
`endif

    int checks = 0;
    int failures = 0;
    bit sbq[$];

    always #5 clk = ~clk;

    run_stream_gen #(.LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_bit   (cmd_bit),
        .cmd_len   (cmd_len),
        .a_out     (a_out),
        .a_valid   (a_valid),
        .run_last  (run_last),
        .busy      (busy)
`ifdef HIST_FLAGS_EN
        ,
        .exp_x     (exp_x),
        .exp_y     (exp_y)
`endif
    );

    typedef struct {
        logic       rst, v, b;
        logic [3:0] len;
        logic       av, ao, rl, rdy, bsy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, v, b, input logic [3:0] len,
                                input logic av, ao, rl, rdy, bsy);
        vec_t t;
        t.rst = rst; t.v = v; t.b = b; t.len = len;
        t.av = av; t.ao = ao; t.rl = rl; t.rdy = rdy; t.bsy = bsy;
        return t;
    endfunction

    // One clock: drive after the edge, sample at the falling edge, keep scoreboard.
    task automatic step(input logic rst, v, b, input logic [3:0] len, output bit acc);
        @(posedge clk);
        #1;
        reset = rst; cmd_valid = v; cmd_bit = b; cmd_len = len;
        @(negedge clk);
        acc = v && cmd_ready && !rst;
        if (a_valid) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected: got bit %b expected no bit at %0t", a_out, $time);
            end else begin
                chk("sb_bit", a_out, sbq.pop_front());
            end
        end
        if (rst) sbq.delete();
        if (acc) for (int k = 0; k < int'(len); k++) sbq.push_back(b);
    endtask

    initial begin
        bit acc;
        int nbits, rl_cnt, rl_at;

        // rst v b len | av ao rl rdy busy
        vq.push_back(mk(1,0,0,0, 0,0,0,1,0));   // reset held 3 cycles
        vq.push_back(mk(1,0,0,0, 0,0,0,1,0));
        vq.push_back(mk(1,0,0,0, 0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,1,0));   // released, idle
        vq.push_back(mk(0,0,0,0, 0,0,0,1,0));
        vq.push_back(mk(0,1,1,3, 0,0,0,1,0));   // accept {1,3}
        vq.push_back(mk(0,0,0,0, 1,1,0,0,1));
        vq.push_back(mk(0,0,0,0, 1,1,0,0,1));
        vq.push_back(mk(0,0,0,0, 1,1,1,1,1));
        vq.push_back(mk(0,0,0,0, 0,1,0,1,0));   // idle, a_out holds 1
        vq.push_back(mk(0,1,1,2, 0,1,0,1,0));   // accept {1,2}
        vq.push_back(mk(0,1,0,3, 1,1,0,0,1));   // {0,3} offered, not ready
        vq.push_back(mk(0,1,0,3, 1,1,1,1,1));   // accepted on run_last
        vq.push_back(mk(0,0,0,0, 1,0,0,0,1));
        vq.push_back(mk(0,0,0,0, 1,0,0,0,1));
        vq.push_back(mk(0,0,0,0, 1,0,1,1,1));
        vq.push_back(mk(0,0,0,0, 0,0,0,1,0));
        vq.push_back(mk(0,1,0,1, 0,0,0,1,0));   // accept {0,1}
        vq.push_back(mk(0,1,1,0, 1,0,1,1,1));   // accept {1,0}
        vq.push_back(mk(0,0,0,0, 0,0,0,1,0));   // gap
        vq.push_back(mk(0,1,0,1, 0,0,0,1,0));   // gap, accept {0,1}
        vq.push_back(mk(0,0,0,0, 1,0,1,1,1));
        vq.push_back(mk(0,0,0,0, 0,0,0,1,0));
        vq.push_back(mk(0,1,1,15,0,0,0,1,0));   // accept {1,15}
        vq.push_back(mk(0,0,0,0, 1,1,0,0,1));
        vq.push_back(mk(0,0,0,0, 1,1,0,0,1));
        vq.push_back(mk(0,0,0,0, 1,1,0,0,1));
        vq.push_back(mk(1,0,0,0, 1,1,0,0,1));   // reset after 4th bit
        vq.push_back(mk(0,0,0,0, 0,0,0,1,0));
        vq.push_back(mk(0,1,0,1, 0,0,0,1,0));   // accept {0,1}
        vq.push_back(mk(0,0,0,0, 1,0,1,1,1));
        vq.push_back(mk(0,0,0,0, 0,0,0,1,0));

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].v, vq[i].b, vq[i].len, acc);
            chk($sformatf("v%0d_a_valid", i), a_valid, vq[i].av);
            chk($sformatf("v%0d_a_out", i), a_out, vq[i].ao);
            chk($sformatf("v%0d_run_last", i), run_last, vq[i].rl);
            chk($sformatf("v%0d_cmd_ready", i), cmd_ready, vq[i].rdy);
            chk($sformatf("v%0d_busy", i), busy, vq[i].bsy);
        end

        // Maximum-length run: exactly 15 bits, run_last only on the 15th.
        step(0, 1, 0, 4'd15, acc);
        chk("max_accept", acc, 1'b1);
        nbits = 0; rl_cnt = 0; rl_at = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, 0, 0, 4'd0, acc);
            if (a_valid) begin
                nbits++;
                if (run_last) begin rl_cnt++; rl_at = nbits; end
            end
        end
        checks++;
        if (nbits != 15 || rl_cnt != 1 || rl_at != 15) begin
            failures++;
            $display("FAIL max_run: got bits=%0d last_count=%0d last_at=%0d expected 15/1/15",
                     nbits, rl_cnt, rl_at);
        end

`ifdef HIST_FLAGS_EN
        begin
            logic [3:0] lens[3] = '{4'd3, 4'd3, 4'd1};
            logic       bits[3] = '{1'b0, 1'b1, 1'b0};
            logic       ex[7]   = '{0,1,1,0,1,1,0};
            logic       ey[7]   = '{0,0,1,0,0,1,0};
            int idx = 0;
            step(1, 0, 0, 4'd0, acc);
            for (int c = 0; c < 3; c++) begin
                acc = 1'b0;
                for (int t = 0; t < 20 && !acc; t++) begin
                    step(0, 1, bits[c], lens[c], acc);
                    if (a_valid && idx < 7) begin
                        chk($sformatf("exp_x_%0d", idx), exp_x, ex[idx]);
                        chk($sformatf("exp_y_%0d", idx), exp_y, ey[idx]);
                        idx++;
                    end
                end
                if (!acc) begin
                    checks++; failures++;
                    $display("FAIL hist_accept_timeout: got no accept expected accept of cmd %0d", c);
                end
            end
            for (int t = 0; t < 20 && idx < 7; t++) begin
                step(0, 0, 0, 4'd0, acc);
                if (a_valid) begin
                    chk($sformatf("exp_x_%0d", idx), exp_x, ex[idx]);
                    chk($sformatf("exp_y_%0d", idx), exp_y, ey[idx]);
                    idx++;
                end else begin
                    chk("gap_exp_x", exp_x, 1'b0);
                    chk("gap_exp_y", exp_y, 1'b0);
                end
            end
            checks++;
            if (idx != 7) begin
                failures++;
                $display("FAIL hist_stream_len: got %0d bits expected 7", idx);
            end
        end
`endif

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending bits expected 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
